// File: rtl/ti_sbox_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ti_sbox_seq
//  Purpose  : Serial scheduler for one shared, pipelined threshold-
//             implementation S-box. A shared state of NIBBLES nibbles (each
//             split into SHARES 4-bit shares) is issued one nibble per cycle
//             into an external S-box pipeline of LATENCY stages. Results are
//             written back in place and the substituted state is offered on
//             a valid/ready handshake.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             in_valid/in_ready  - input handshake, din = shared state
//             out_valid/out_ready- output handshake, dout = substituted state
//             sb_valid/sb_in     - nibble issued to the external S-box
//             sb_out             - S-box result, LATENCY cycles after issue
//             rnd                - fresh randomness for share refresh
//  Layout   : nibble i share s at bits [(i*SHARES+s)*4 +: 4]
//  Option   : TI_SEQ_REFRESH_EN - re-mask every nibble with rnd on issue
//  Revision : 1.0 - initial release
// ============================================================================
module ti_sbox_seq #(
   parameter int NIBBLES = 16,
   parameter int SHARES  = 3,
   parameter int LATENCY = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [4*SHARES*NIBBLES-1:0]   din,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [4*SHARES*NIBBLES-1:0]   dout,
   output logic                          sb_valid,
   output logic [4*SHARES-1:0]           sb_in,
   input  logic [4*SHARES-1:0]           sb_out,
   input  logic [4*(SHARES-1)-1:0]       rnd
);

   localparam int STATE_W = 4 * SHARES * NIBBLES;
   localparam int SLOT_W  = 4 * SHARES;
   localparam int CNT_W   = $clog2(NIBBLES + 1);
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } fsm_t;

   fsm_t                 fsm_q, fsm_d;
   logic [STATE_W-1:0]   slots_q, slots_d;
   logic [CNT_W-1:0]     issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]     ret_cnt_q, ret_cnt_d;
   logic [LATENCY-1:0]   vpipe_q, vpipe_d;
   logic [SLOT_W-1:0]    issue_slot;
   logic [SLOT_W-1:0]    issue_masked;
   logic                 ret_valid;

   // Tail of the valid pipe lines up exactly with the S-box result of the
   // nibble issued LATENCY cycles earlier.
   assign ret_valid = vpipe_q[LATENCY-1];

   generate
      if (LATENCY == 1) begin : g_vpipe_single
         assign vpipe_d = sb_valid;
      end else begin : g_vpipe_shift
         assign vpipe_d = {vpipe_q[LATENCY-2:0], sb_valid};
      end
   endgenerate

   // Only meaningful during ISSUE; outside it the counter may point past the
   // last slot, which is why sb_in is gated by sb_valid below.
   assign issue_slot = slots_q[int'(issue_cnt_q)*SLOT_W +: SLOT_W];

`ifdef TI_SEQ_REFRESH_EN
   // Fresh masks on shares 0..SHARES-2; the last share absorbs the XOR of all
   // masks so the unshared nibble is unchanged.
   logic [3:0] rnd_sum;
   always_comb begin
      rnd_sum      = '0;
      issue_masked = issue_slot;
      for (int s = 0; s < SHARES-1; s++) begin
         rnd_sum                = rnd_sum ^ rnd[s*4 +: 4];
         issue_masked[s*4 +: 4] = issue_slot[s*4 +: 4] ^ rnd[s*4 +: 4];
      end
      issue_masked[(SHARES-1)*4 +: 4] = issue_slot[(SHARES-1)*4 +: 4] ^ rnd_sum;
   end
`else
   logic rnd_unused;
   assign rnd_unused   = ^rnd;
   assign issue_masked = issue_slot;
`endif

   assign sb_in = sb_valid ? issue_masked : '0;
   assign dout  = slots_q;

   always_comb begin
      fsm_d       = fsm_q;
      slots_d     = slots_q;
      issue_cnt_d = issue_cnt_q;
      ret_cnt_d   = ret_cnt_q;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      sb_valid    = 1'b0;

      case (fsm_q)
         S_IDLE: begin
            in_ready = ~rst;
            if (in_valid) begin
               slots_d     = din;
               issue_cnt_d = '0;
               ret_cnt_d   = '0;
               fsm_d       = S_ISSUE;
            end
         end
         S_ISSUE: begin
            sb_valid    = 1'b1;
            issue_cnt_d = issue_cnt_q + 1'b1;
            if (issue_cnt_q == LAST_SLOT) begin
               fsm_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (ret_valid && (ret_cnt_q == LAST_SLOT)) begin
               fsm_d = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               fsm_d = S_IDLE;
            end
         end
         default: fsm_d = S_IDLE;
      endcase

      // Results return in issue order, so a running counter locates the slot.
      // A slot is always issued LATENCY cycles before its result overwrites it.
      if (ret_valid) begin
         slots_d[int'(ret_cnt_q)*SLOT_W +: SLOT_W] = sb_out;
         ret_cnt_d = ret_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q       <= S_IDLE;
         slots_q     <= '0;
         issue_cnt_q <= '0;
         ret_cnt_q   <= '0;
         vpipe_q     <= '0;
      end else begin
         fsm_q       <= fsm_d;
         slots_q     <= slots_d;
         issue_cnt_q <= issue_cnt_d;
         ret_cnt_q   <= ret_cnt_d;
         vpipe_q     <= vpipe_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ti_sbox_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ti_sbox_seq
//  Purpose  : Self-checking bench for ti_sbox_seq. A default instance
//             (16 nibbles, 3 shares, latency 2) and a minimal instance
//             (1 nibble, latency 1) each drive a behavioural S-box stub.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ti_sbox_seq;

   localparam int NIB = 16;
   localparam int SH  = 3;
   localparam int LAT = 2;
   localparam int W   = 4*SH*NIB;
   localparam int SW  = 4*SH;
   localparam int RW  = 4*(SH-1);
   localparam int EXP_LAT = NIB + LAT + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0, out_ready = 1'b1;
   logic          in_ready, out_valid, sb_valid;
   logic [W-1:0]  din = '0, dout;
   logic [SW-1:0] sb_in, sb_out;
   logic [RW-1:0] rnd = '0;

   logic          in_valid2 = 1'b0, out_ready2 = 1'b1;
   logic          in_ready2, out_valid2, sb_valid2;
   logic [SW-1:0] din2 = '0, dout2, sb_in2, sb_out2;

   int checks = 0;
   int errors = 0;
   bit real_mode = 1'b0;
   logic [W-1:0] exp_q[$];
   logic [3:0] sbox_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   always #5 clk = ~clk;

   ti_sbox_seq #(.NIBBLES(NIB), .SHARES(SH), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
      .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
      .sb_valid(sb_valid), .sb_in(sb_in), .sb_out(sb_out), .rnd(rnd));

   ti_sbox_seq #(.NIBBLES(1), .SHARES(SH), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .din(din2),
      .out_valid(out_valid2), .out_ready(out_ready2), .dout(dout2),
      .sb_valid(sb_valid2), .sb_in(sb_in2), .sb_out(sb_out2), .rnd(rnd));

   // Shared S-box stub: unshare, substitute, re-share with fresh randomness.
   function automatic logic [SW-1:0] ti_stub(input logic [SW-1:0] x);
      logic [3:0] v, r1, r2;
      v  = sbox_t[x[3:0] ^ x[7:4] ^ x[11:8]];
      r1 = 4'($urandom);
      r2 = 4'($urandom);
      return {v ^ r1 ^ r2, r2, r1};
   endfunction

   logic [SW-1:0] sb_pipe [LAT];
   always @(posedge clk) begin
      sb_pipe[0] <= real_mode ? ti_stub(sb_in) : sb_in;
      for (int i = 1; i < LAT; i++) sb_pipe[i] <= sb_pipe[i-1];
   end
   assign sb_out = sb_pipe[LAT-1];

   always @(posedge clk) sb_out2 <= sb_in2;

   initial forever begin
      @(posedge clk); #1;
      rnd = RW'($urandom);
   end

   function automatic logic [4*NIB-1:0] unshare(input logic [W-1:0] d);
      logic [4*NIB-1:0] u;
      u = '0;
      for (int i = 0; i < NIB; i++)
         for (int s = 0; s < SH; s++)
            u[i*4 +: 4] = u[i*4 +: 4] ^ d[(i*SH+s)*4 +: 4];
      return u;
   endfunction

   function automatic logic [4*NIB-1:0] subst(input logic [4*NIB-1:0] u);
      logic [4*NIB-1:0] r;
      for (int i = 0; i < NIB; i++) r[i*4 +: 4] = sbox_t[u[i*4 +: 4]];
      return r;
   endfunction

   function automatic logic [W-1:0] rand_state();
      logic [W-1:0] r;
      for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Runs one state through the default instance with out_ready held high.
   task automatic drive_state(input logic [W-1:0] d, output logic [W-1:0] q,
                              output int lat, output int sb_cnt,
                              output int sb_first, output int sb_last, output bit to);
      to = 1'b0; lat = -1; sb_cnt = 0; sb_first = -1; sb_last = -1; q = '0;
      for (int k = 0; k < 50 && !in_ready; k++) begin @(posedge clk); #1; end
      if (!in_ready) begin to = 1'b1; return; end
      din = d; in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (sb_valid) begin
            sb_cnt++;
            if (sb_first < 0) sb_first = k;
            sb_last = k;
         end
         if (out_valid) begin lat = k; q = dout; break; end
      end
      if (lat < 0) to = 1'b1;
      else begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || in_ready2 !== 1'b0) begin
         errors++; $display("FAIL reset_in_ready got %b/%b expected 0/0", in_ready, in_ready2);
      end
      checks++;
      if (out_valid !== 1'b0 || sb_valid !== 1'b0 || sb_in !== '0 || dout !== '0) begin
         errors++;
         $display("FAIL reset_outputs got ov=%b sv=%b sb_in=%h dout=%h expected all 0",
                  out_valid, sb_valid, sb_in, dout);
      end
      checks++;
      if (out_valid2 !== 1'b0 || sb_valid2 !== 1'b0 || dout2 !== '0) begin
         errors++; $display("FAIL reset_outputs_n1 got ov=%b sv=%b dout=%h expected 0",
                            out_valid2, sb_valid2, dout2);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || in_ready2 !== 1'b1) begin
         errors++; $display("FAIL idle_in_ready got %b/%b expected 1/1", in_ready, in_ready2);
      end
   endtask

   task automatic test_identity();
      logic [W-1:0] d, q, e;
      logic [63:0] pat;
      int lat, cnt, f, l;
      bit to;
      real_mode = 1'b0;
      pat = 64'h0123456789ABCDEF;
      d = {pat, pat, pat};
      exp_q.push_back(d);
      drive_state(d, q, lat, cnt, f, l, to);
      e = exp_q.pop_front();
      checks++;
      if (to) begin errors++; $display("FAIL identity_timeout got timeout expected completion"); end
      checks++;
      if (lat !== EXP_LAT) begin
         errors++; $display("FAIL identity_latency got %0d expected %0d", lat, EXP_LAT);
      end
      checks++;
      if (cnt !== NIB || f !== 1 || l !== NIB) begin
         errors++; $display("FAIL identity_sb_valid got cnt=%0d first=%0d last=%0d expected %0d/1/%0d",
                            cnt, f, l, NIB, NIB);
      end
`ifdef TI_SEQ_REFRESH_EN
      checks++;
      if (unshare(q) !== unshare(e)) begin
         errors++; $display("FAIL refresh_unshared got %h expected %h", unshare(q), unshare(e));
      end
      checks++;
      if (q === e) begin errors++; $display("FAIL refresh_masked got %h expected shares differing from %h", q, e); end
`else
      checks++;
      if (q !== e) begin errors++; $display("FAIL identity_data got %h expected %h", q, e); end
`endif
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] d0, d1, q, e;
      int lat, cnt, f, l;
      bit to;
      real_mode = 1'b0;
      d0 = rand_state();
      d1 = rand_state();
      exp_q.push_back(d0);
      exp_q.push_back(d1);
      for (int r = 0; r < 2; r++) begin
         drive_state((r == 0) ? d0 : d1, q, lat, cnt, f, l, to);
         e = exp_q.pop_front();
         checks++;
         if (to || lat !== EXP_LAT) begin
            errors++; $display("FAIL b2b_latency_%0d got %0d expected %0d", r, lat, EXP_LAT);
         end
         checks++;
`ifdef TI_SEQ_REFRESH_EN
         if (unshare(q) !== unshare(e)) begin
            errors++; $display("FAIL b2b_data_%0d got %h expected %h", r, unshare(q), unshare(e));
         end
`else
         if (q !== e) begin errors++; $display("FAIL b2b_data_%0d got %h expected %h", r, q, e); end
`endif
      end
   endtask

   task automatic test_ti_sbox();
      logic [W-1:0] d, q, e;
      int lat, cnt, f, l;
      bit to;
      real_mode = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         d = rand_state();
         exp_q.push_back(W'(subst(unshare(d))));
         drive_state(d, q, lat, cnt, f, l, to);
         e = exp_q.pop_front();
         checks++;
         if (to || unshare(q) !== e[4*NIB-1:0]) begin
            errors++; $display("FAIL ti_sbox_%0d got %h expected %h timeout=%0d",
                               n, unshare(q), e[4*NIB-1:0], to);
         end
      end
      real_mode = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [W-1:0] d, held, e;
      int lat;
      real_mode = 1'b0;
      d = rand_state();
      exp_q.push_back(d);
      for (int k = 0; k < 50 && !in_ready; k++) begin @(posedge clk); #1; end
      din = d; in_valid = 1'b1; out_ready = 1'b0;
      lat = -1;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (out_valid) begin lat = k; break; end
      end
      checks++;
      if (lat !== EXP_LAT) begin errors++; $display("FAIL bp_latency got %0d expected %0d", lat, EXP_LAT); end
      held = dout;
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         din = ~d;
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || dout !== held) begin
            errors++; $display("FAIL bp_hold_%0d got ov=%b ir=%b dout=%h expected 1/0/%h",
                               c, out_valid, in_ready, dout, held);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || sb_valid !== 1'b0) begin
         errors++; $display("FAIL bp_release got ov=%b ir=%b sv=%b expected 0/1/0",
                            out_valid, in_ready, sb_valid);
      end
      e = exp_q.pop_front();
      checks++;
`ifdef TI_SEQ_REFRESH_EN
      if (unshare(held) !== unshare(e)) begin
         errors++; $display("FAIL bp_data got %h expected %h", unshare(held), unshare(e));
      end
`else
      if (held !== e) begin errors++; $display("FAIL bp_data got %h expected %h", held, e); end
`endif
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] d_old, d_new, q, e;
      int lat, cnt, f, l;
      bit to;
      real_mode = 1'b0;
      d_old = rand_state();
      d_new = rand_state();
      for (int k = 0; k < 50 && !in_ready; k++) begin @(posedge clk); #1; end
      din = d_old; in_valid = 1'b1;
      for (int k = 1; k <= 6; k++) begin @(posedge clk); #1; in_valid = 1'b0; end
      checks++;
      if (sb_valid !== 1'b1) begin errors++; $display("FAIL midrst_issuing got %b expected 1", sb_valid); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || sb_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL midrst_state got ov=%b sv=%b ir=%b expected 0/0/1",
                            out_valid, sb_valid, in_ready);
      end
      exp_q.push_back(d_new);
      drive_state(d_new, q, lat, cnt, f, l, to);
      e = exp_q.pop_front();
      checks++;
      if (to || lat !== EXP_LAT) begin
         errors++; $display("FAIL midrst_latency got %0d expected %0d", lat, EXP_LAT);
      end
      checks++;
`ifdef TI_SEQ_REFRESH_EN
      if (unshare(q) !== unshare(e)) begin
         errors++; $display("FAIL midrst_data got %h expected %h", unshare(q), unshare(e));
      end
`else
      if (q !== e) begin errors++; $display("FAIL midrst_data got %h expected %h", q, e); end
`endif
   endtask

   task automatic test_single_nibble();
      logic [SW-1:0] d2, q2;
      logic [W-1:0] e;
      int lat, cnt;
      d2 = SW'($urandom);
      exp_q.push_back(W'(d2));
      for (int k = 0; k < 50 && !in_ready2; k++) begin @(posedge clk); #1; end
      din2 = d2; in_valid2 = 1'b1; out_ready2 = 1'b1;
      lat = -1; cnt = 0; q2 = '0;
      for (int k = 1; k <= 50; k++) begin
         @(posedge clk); #1;
         in_valid2 = 1'b0;
         if (sb_valid2) cnt++;
         if (out_valid2) begin lat = k; q2 = dout2; break; end
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL n1_latency got %0d expected 3", lat); end
      checks++;
      if (cnt !== 1) begin errors++; $display("FAIL n1_sb_valid got %0d expected 1", cnt); end
      checks++;
`ifdef TI_SEQ_REFRESH_EN
      if ((q2[3:0] ^ q2[7:4] ^ q2[11:8]) !== (e[3:0] ^ e[7:4] ^ e[11:8])) begin
         errors++; $display("FAIL n1_data got %h expected %h", q2[3:0] ^ q2[7:4] ^ q2[11:8],
                            e[3:0] ^ e[7:4] ^ e[11:8]);
      end
`else
      if (q2 !== e[SW-1:0]) begin errors++; $display("FAIL n1_data got %h expected %h", q2, e[SW-1:0]); end
`endif
      checks++;
      if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin
         errors++; $display("FAIL n1_idle got ir=%b ov=%b expected 1/0", in_ready2, out_valid2);
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_single_nibble();
      test_ti_sbox();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
